// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter for the cpu_core data bus.
// Register window of 16 bytes at BASE_ADDR: TXDATA, STATUS, BAUDDIV, IRQEN/reserved.
// Bytes written to TXDATA queue in a FIFO_DEPTH-entry FIFO; a serial FSM drains
// the FIFO onto txd, one frame per byte, LSB first.
// Optional feature: define UART_TX_IRQ_EN to add the irq output and the IRQEN
// register at offset 0xC.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [31:0] memAddr,
   input  logic [31:0] memDataIn,
   output logic [31:0] dataOut,
   output logic        sel,
   output logic        txd
`ifdef UART_TX_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [AW-1:0] ONE_P   = AW'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // Register offsets within the window (word index memAddr[3:2]).
   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_BAUDDIV = 2'd2;

   state_t        state_q, state_d;
   logic [15:0]   baud_cnt_q, baud_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          overflow_q;
   logic [15:0]   bauddiv_q;

   logic [1:0]    reg_idx;
   logic          wr_en;
   logic          push_req, push_ok, pop, full, empty, busy;
   logic [31:0]   status_word;

   // Address bits [1:0] and write data above bit 15 have no meaning here.
   logic          unused_ok;
   assign unused_ok = ^{memAddr[1:0], memDataIn[31:16]};

   assign sel     = (memAddr[31:4] == BASE_ADDR[31:4]);
   assign reg_idx = memAddr[3:2];
   assign wr_en   = memWrite & sel;

   assign full     = (count_q == DEPTH_C);
   assign empty    = (count_q == '0);
   assign busy     = (state_q != IDLE);
   assign push_req = wr_en && (reg_idx == REG_TXDATA);
   // A push into a full FIFO still lands if the FSM pops the head this cycle.
   assign push_ok  = push_req && (!full || pop);

   assign status_word = {16'b0, 8'(count_q), 4'b0, overflow_q, empty, full, busy};

`ifdef UART_TX_IRQ_EN
   logic [1:0] irqen_q;
`endif

   // Bus read mux: combinational, zero unless a read hits the window.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      dataOut = 32'b0;
      if (sel && memRead) begin
         case (reg_idx)
            REG_STATUS:  dataOut = status_word;
            REG_BAUDDIV: dataOut = {16'b0, bauddiv_q};
`ifdef UART_TX_IRQ_EN
            2'd3:        dataOut = {30'b0, irqen_q};
`endif
            default:     dataOut = 32'b0;
         endcase
      end
   end

   // Serial FSM next-state and txd decode.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      pop        = 1'b0;
      txd        = 1'b1;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shift_d    = fifo_mem[rd_ptr_q];
               baud_cnt_d = bauddiv_q - 16'd1;
               state_d    = START;
            end
         end
         START: begin
            txd = 1'b0;
            if (baud_cnt_q == 16'd0) begin
               baud_cnt_d = bauddiv_q - 16'd1;
               bit_idx_d  = 3'd0;
               state_d    = DATA;
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end
         DATA: begin
            txd = shift_q[0];
            if (baud_cnt_q == 16'd0) begin
               baud_cnt_d = bauddiv_q - 16'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end
         STOP: begin
            txd = 1'b1;
            if (baud_cnt_q == 16'd0) begin
               state_d = IDLE;
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Serial FSM state register.
   always_ff @(posedge CLK) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      if (RES) begin
         state_q    <= IDLE;
         baud_cnt_q <= 16'd0;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
      end
   end

   // FIFO storage: write-only on accepted pushes.
   always_ff @(posedge CLK) begin
      // NOTE: the data array is not reset; pointers and count define which entries are valid.
      if (push_ok) begin
         fifo_mem[wr_ptr_q] <= memDataIn[7:0];
      end
   end

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge CLK) begin
      if (RES) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + ONE_P;
         if (pop)     rd_ptr_q <= rd_ptr_q + ONE_P;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + ONE_C;
            2'b01:   count_q <= count_q - ONE_C;
            default: count_q <= count_q;
         endcase
         if (push_req && !push_ok) begin
            overflow_q <= 1'b1;
         end else if (wr_en && (reg_idx == REG_STATUS) && memDataIn[3]) begin
            overflow_q <= 1'b0;
         end
      end
   end

   // Baud divisor register; zero is stored as one so a bit always lasts a cycle.
   always_ff @(posedge CLK) begin
      if (RES) begin
         bauddiv_q <= DEFAULT_DIV;
      end else if (wr_en && (reg_idx == REG_BAUDDIV)) begin
         bauddiv_q <= (memDataIn[15:0] == 16'd0) ? 16'd1 : memDataIn[15:0];
      end
   end

`ifdef UART_TX_IRQ_EN
   // Interrupt enable register and registered interrupt output.
   always_ff @(posedge CLK) begin
      if (RES) begin
         irqen_q <= 2'b00;
         irq     <= 1'b0;
      end else begin
         if (wr_en && (reg_idx == 2'd3)) begin
            irqen_q <= memDataIn[1:0];
         end
         irq <= (irqen_q[0] & empty & ~busy) | (irqen_q[1] & overflow_q);
      end
   end
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench for mmio_uart_tx.
// Stimulus pushes expected read data and expected transmitted bytes into queues;
// a read monitor and a serial frame decoder pop and compare independently.
// Define UART_TX_IRQ_EN to also exercise the irq output.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'hFFFF_0000;
   localparam logic [31:0] A_TX = BASE + 32'h0;
   localparam logic [31:0] A_ST = BASE + 32'h4;
   localparam logic [31:0] A_BD = BASE + 32'h8;
   localparam logic [31:0] A_IE = BASE + 32'hC;

   logic        CLK = 1'b0;
   logic        RES;
   logic        memRead, memWrite;
   logic [31:0] memAddr, memDataIn;
   logic [31:0] dataOut;
   logic        sel, txd;
`ifdef UART_TX_IRQ_EN
   logic        irq;
`endif

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_rd [$];
   logic [7:0]  exp_byte [$];
   int  cur_div = 868;
   bit  mon_busy = 1'b0;

   mmio_uart_tx dut (
      .CLK       (CLK),
      .RES       (RES),
      .memRead   (memRead),
      .memWrite  (memWrite),
      .memAddr   (memAddr),
      .memDataIn (memDataIn),
      .dataOut   (dataOut),
      .sel       (sel),
      .txd       (txd)
`ifdef UART_TX_IRQ_EN
      ,
      .irq       (irq)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Bus tasks: called #1 after a rising edge, return #1 after the next one.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      memWrite = 1'b1; memAddr = a; memDataIn = d;
      @(posedge CLK); #1;
      memWrite = 1'b0; memRead = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp);
      memRead = 1'b1; memAddr = a;
      exp_rd.push_back(exp);
      @(posedge CLK); #1;
      memRead = 1'b0;
   endtask

   task automatic rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
      memRead = 1'b1; memWrite = 1'b1; memAddr = a; memDataIn = d;
      exp_rd.push_back(exp);
      @(posedge CLK); #1;
      memRead = 1'b0; memWrite = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n = 0;
      while ((exp_byte.size() != 0 || mon_busy) && n < budget) begin
         @(posedge CLK);
         n++;
      end
      #1;
      check({name, " drained in budget"}, 32'(n < budget), 32'd1);
   endtask

   // Read monitor: compares dataOut mid-cycle whenever a read is on the bus.
   always @(negedge CLK) begin
      if (memRead) begin
         if (exp_rd.size() == 0) begin
            tests++; fails++;
            $display("FAIL read_unexpected: got 0x%08h, expected no read", dataOut);
         end else begin
            check($sformatf("read@%h", memAddr[3:0]), dataOut, exp_rd.pop_front());
         end
      end
   end

   // Frame monitor: waits n falling edges, abandoning the frame if reset is seen.
   task automatic mon_wait(input int n, inout bit ab);
      repeat (n) begin
         if (!ab) begin
            @(negedge CLK);
            if (RES) ab = 1'b1;
         end
      end
   endtask

   // Serial decoder: samples each bit at its midpoint using the current divisor.
   initial begin : frame_mon
      logic [7:0] data;
      logic       st, sb;
      bit         ab;
      int         div;
      forever begin
         @(negedge CLK);
         if (RES === 1'b0 && txd === 1'b0) begin
            mon_busy = 1'b1;
            div = cur_div;
            ab = 1'b0;
            data = 8'h00;
            mon_wait(div / 2, ab);
            st = txd;
            for (int i = 0; i < 8; i++) begin
               mon_wait(div, ab);
               data[i] = txd;
            end
            mon_wait(div, ab);
            sb = txd;
            if (!ab) begin
               check("start bit", 32'(st), 32'd0);
               check("stop bit", 32'(sb), 32'd1);
               if (exp_byte.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL frame_unexpected: got 0x%02h, expected no frame", data);
               end else begin
                  check("frame byte", 32'(data), 32'(exp_byte.pop_front()));
               end
            end
            mon_busy = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int lows;
      RES = 1'b1; memRead = 1'b0; memWrite = 1'b0; memAddr = BASE; memDataIn = 32'h0;
      idle(3);
      RES = 1'b0;

      // Reset state.
      rd(A_ST, 32'h0000_0004);
      rd(A_BD, 32'h0000_0364);
      check("txd idle after reset", 32'(txd), 32'd1);
`ifndef UART_TX_IRQ_EN
      rd(A_IE, 32'h0);
`endif

      // Single frame 0xA5 at 4 cycles/bit.
      wr(A_BD, 32'd4); cur_div = 4;
      wr(A_TX, 32'hA5); exp_byte.push_back(8'hA5);
      idle(5);
      rd(A_ST, 32'h0000_0005);
      rd(A_TX, 32'h0);
      wait_drain(100, "frame A5");
      idle(8);
      rd(A_ST, 32'h0000_0004);

      // Nine back-to-back pushes: the first pop frees a slot, all nine go out.
      for (int i = 0; i < 9; i++) begin
         wr(A_TX, 32'(i));
         exp_byte.push_back(8'(i));
      end
      wait_drain(9 * 45 + 50, "nine frames");
      idle(8);

      // Slow divisor, ten pushes: tenth dropped, overflow sticky until W1C.
      wr(A_BD, 32'd1000); cur_div = 1000;
      for (int i = 0; i < 10; i++) wr(A_TX, 32'(i));
      rd(A_ST, 32'h0000_080B);
      wr(A_ST, 32'h0000_0008);
      rd(A_ST, 32'h0000_0803);
      RES = 1'b1; @(posedge CLK); #1; RES = 1'b0; cur_div = 868;
      rd(A_ST, 32'h0000_0004);
      rd(A_BD, 32'h0000_0364);

      // Divisor 0 stores 1; frames at one cycle per bit.
      wr(A_BD, 32'd0);
      rd(A_BD, 32'd1); cur_div = 1;
      wr(A_TX, 32'h3C); exp_byte.push_back(8'h3C);
      wr(A_TX, 32'h81); exp_byte.push_back(8'h81);
      wait_drain(100, "div1 frames");
      idle(4);
      // Read and write together: read shows the pre-edge divisor.
      rw(A_BD, 32'h0001_0004, 32'd1);
      rd(A_BD, 32'd4); cur_div = 4;

      // Access just past the window: not selected, nothing pushed.
      memAddr = BASE + 32'h10; memWrite = 1'b1; memDataIn = 32'h55;
      #1;
      check("sel outside window", 32'(sel), 32'd0);
      @(posedge CLK); #1; memWrite = 1'b0;
      rd(BASE + 32'h10, 32'h0);
      rd(A_ST, 32'h0000_0004);
      idle(20);

      // Reset in the middle of data bit 3: line returns idle, frame abandoned.
      wr(A_TX, 32'h5A);
      idle(17);
      RES = 1'b1; @(posedge CLK); #1; RES = 1'b0; cur_div = 868;
      check("txd after mid-frame reset", 32'(txd), 32'd1);
      rd(A_ST, 32'h0000_0004);
      lows = 0;
      repeat (60) begin
         @(negedge CLK);
         if (txd == 1'b0) lows++;
      end
      check("no residual frame", 32'(lows), 32'd0);

`ifdef UART_TX_IRQ_EN
      // Empty-and-idle interrupt.
      @(posedge CLK); #1;
      wr(A_BD, 32'd4); cur_div = 4;
      wr(A_IE, 32'd1);
      rd(A_IE, 32'd1);
      idle(2);
      check("irq idle empty", 32'(irq), 32'd1);
      wr(A_TX, 32'h96); exp_byte.push_back(8'h96);
      idle(3);
      check("irq while busy", 32'(irq), 32'd0);
      wait_drain(100, "irq frame");
      idle(8);
      check("irq after frame", 32'(irq), 32'd1);
`endif

      idle(4);
      check("read queue drained", 32'(exp_rd.size()), 32'd0);
      check("frame queue drained", 32'(exp_byte.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
